// File: rtl/ro_freq_counter.sv
// ro_freq_counter
// -----------------------------------------------------------------------------
// Ring-oscillator frequency counter. One of NUM_CH asynchronous oscillator
// outputs is selected, synchronised into the wishbone clock domain, and its
// rising edges are counted over a programmable gate window.
//
// A measurement runs as follows:
//   - the oscillators are enabled (ro_start);
//   - the block waits SETTLE_CYC cycles for them to settle;
//   - rising edges are counted for win_len cycles;
//   - the saturating result is published on count/overflow with a one-cycle
//     done pulse.
//
// The selected raw oscillator is also forwarded combinationally to ro_obs so
// it can be routed to a pad and watched on a scope.
//
// Usage limit: the oscillator frequency must be below f(wb_clk_i)/2. Faster
// inputs alias through the synchroniser. This is not detected.
//
// Build option:
//   RO_FREQ_CONTINUOUS_EN - when defined, the block re-arms after every
//   window. It skips the settle phase, keeps ro_start high and reuses the
//   latched channel and window, pulsing done every win_q+1 cycles until
//   abort. When undefined, each start produces a single measurement.
//
// Ports:
//   wb_clk_i   sole clock
//   wb_rst_ni  asynchronous active-low reset
//   ro_in      raw oscillator outputs (asynchronous)
//   ch_sel     channel to measure, sampled when start is accepted
//   win_len    gate window length in wb_clk_i cycles, sampled on start
//   start      measurement request (pulse or level)
//   abort      cancel a measurement in progress
//   ro_start   oscillator enable, fans out to every oscillator
//   ro_obs     raw ro_in[ch_q] for pad observation
//   busy       measurement in progress
//   done       one-cycle pulse, count/overflow just updated
//   count      edges counted in the last completed window (saturating)
//   overflow   count saturated during the last completed window
//   sel_err    last accepted ch_sel was out of range (channel 0 was used)
// -----------------------------------------------------------------------------
module ro_freq_counter #(
  parameter int unsigned NUM_CH     = 10,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned WIN_W      = 20,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              start,
  input  logic              abort,
  output logic              ro_start,
  output logic              ro_obs,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              sel_err
);

  // The cycle counter is shared between the settle and measure phases, so it
  // must be wide enough for whichever of the two is longer.
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CYC_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  localparam logic [CYC_W-1:0] CycOne     = CYC_W'(1);
  localparam logic [CYC_W-1:0] SettleLast = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [SEL_W:0]   NumChW     = (SEL_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              sel_err_q, sel_err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  // sync_q[0..1] form the two-flop synchroniser, sync_q[2] is the edge
  // detector history flop.
  logic [2:0]        sync_q;
  logic              ro_sel;
  logic              ro_rise;
  logic              running;

  // ch_q is always in range: out-of-range requests are forced to channel 0.
  assign ro_sel  = ro_in[ch_q];
  assign ro_obs  = ro_sel;
  assign ro_rise = sync_q[1] & ~sync_q[2];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    win_d     = win_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sel_err_d = sel_err_q;

    unique case (state_q)
      StIdle: begin
        // abort has priority over a simultaneous start.
        if (start && !abort) begin
          sel_err_d = ({1'b0, ch_sel} >= NumChW);
          ch_d      = sel_err_d ? '0 : ch_sel;
          win_d     = win_len;
          cyc_d     = SettleLast;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = StSettle;
        end
      end

      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cyc_q == '0) begin
          // A zero-length window skips the measure phase entirely.
          if (win_q == '0) begin
            state_d = StDone;
          end else begin
            state_d = StMeasure;
            cyc_d   = CYC_W'(win_q) - CycOne;
          end
        end else begin
          cyc_d = cyc_q - CycOne;
        end
      end

      StMeasure: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (ro_rise) begin
            if (cnt_q == CntMax) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end
          if (cyc_q == '0) begin
            state_d = StDone;
          end else begin
            cyc_d = cyc_q - CycOne;
          end
        end
      end

      StDone: begin
`ifdef RO_FREQ_CONTINUOUS_EN
        // Re-arm on the same channel/window without settling again.
        if (abort) begin
          state_d = StIdle;
        end else begin
          cnt_d = '0;
          ovf_d = 1'b0;
          if (win_q == '0) begin
            state_d = StDone;
          end else begin
            state_d = StMeasure;
            cyc_d   = CYC_W'(win_q) - CycOne;
          end
        end
`else
        state_d = StIdle;
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result publication: the window result is registered out of the DONE
  // cycle, so done/count/overflow change together one cycle after DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    if (state_q == StDone) begin
      count_d    = cnt_q;
      overflow_d = ovf_q;
      done_d     = 1'b1;
    end
  end

`ifdef RO_FREQ_CONTINUOUS_EN
  assign running = (state_q == StSettle) || (state_q == StMeasure) ||
                   (state_q == StDone);
`else
  assign running = (state_q == StSettle) || (state_q == StMeasure);
`endif

  assign ro_start = running;
  assign busy     = running;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign sel_err  = sel_err_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      win_q      <= '0;
      cyc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sel_err_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      win_q      <= win_d;
      cyc_q      <= cyc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sel_err_q  <= sel_err_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      sync_q     <= {sync_q[1:0], ro_sel};
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter (single-shot build). Synthetic
// oscillators toggle on the falling clock edge with per-channel half periods.
// Each accepted start pushes its expected result onto a scoreboard. A monitor
// pops and checks an entry on every done pulse.
module tb_ro_freq_counter;

  localparam int unsigned NumCh  = 10;
  localparam int unsigned CntW   = 8;
  localparam int unsigned WinW   = 12;
  localparam int unsigned Settle = 16;
  localparam int unsigned SelW   = 4;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NumCh-1:0]  ro_in   = '0;
  logic [SelW-1:0]   ch_sel  = '0;
  logic [WinW-1:0]   win_len = '0;
  logic              start   = 1'b0;
  logic              abort   = 1'b0;
  logic              ro_start;
  logic              ro_obs;
  logic              busy;
  logic              done;
  logic [CntW-1:0]   count;
  logic              overflow;
  logic              sel_err;

  ro_freq_counter #(
    .NUM_CH     (NumCh),
    .CNT_W      (CntW),
    .WIN_W      (WinW),
    .SETTLE_CYC (Settle)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .ro_in     (ro_in),
    .ch_sel    (ch_sel),
    .win_len   (win_len),
    .start     (start),
    .abort     (abort),
    .ro_start  (ro_start),
    .ro_obs    (ro_obs),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .overflow  (overflow),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned cnt;
    int unsigned tol;
    logic        ovf;
    logic        sel;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          total     = 0;
  int          bad       = 0;
  int unsigned cyc       = 0;
  int unsigned done_seen = 0;
  int unsigned half[NumCh];
  int unsigned tick[NumCh];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synthetic oscillators: channel i has period 2*half[i] clock cycles.
  initial begin
    for (int i = 0; i < NumCh; i++) begin
      half[i] = 10;
      tick[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NumCh; i++) begin
        tick[i]++;
        if (tick[i] >= half[i]) begin
          tick[i]  = 0;
          ro_in[i] = ~ro_in[i];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer.
  initial begin
    exp_t        e;
    int unsigned lo;
    int unsigned hi;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen++;
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_done: observed done=1 at cycle %0d, required none pending", cyc);
        end
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          lo = (e.cnt > e.tol) ? e.cnt - e.tol : 0;
          hi = e.cnt + e.tol;
          total++;
          assert (32'(count) >= lo && 32'(count) <= hi) else begin
            bad++;
            $error("FAIL %s_count: observed %0d required %0d..%0d", e.tag, count, lo, hi);
          end
          chk($sformatf("%s_overflow", e.tag), 32'(overflow), 32'(e.ovf));
          chk($sformatf("%s_sel_err", e.tag), 32'(sel_err), 32'(e.sel));
          chk($sformatf("%s_latency", e.tag), cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Pulse start for one cycle; optionally record the expected result.
  task automatic issue(input logic [SelW-1:0] sel, input int unsigned win,
                       input int unsigned exp_cnt, input int unsigned tol,
                       input logic exp_ovf, input logic exp_sel,
                       input string tag, input bit push);
    exp_t e;
    @(negedge clk);
    ch_sel  = sel;
    win_len = WinW'(win);
    start   = 1'b1;
    if (push) begin
      e.tag = tag;
      e.cnt = exp_cnt;
      e.tol = tol;
      e.ovf = exp_ovf;
      e.sel = exp_sel;
      e.acc = cyc + 1;
      e.lat = 1 + Settle + win;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    // Disturb the sampled inputs; the latched copies must be used.
    ch_sel  = 4'd9;
    win_len = WinW'(5);
    chk($sformatf("%s_busy", tag), 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int unsigned limit, input string tag);
    int unsigned n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL %s_timeout: observed %0d pending after %0d cycles, required 0",
             tag, sb.size(), limit);
      sb.delete();
    end
  endtask

  initial begin
    int unsigned d0;

    // Reset values
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ro_start", 32'(ro_start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic: period 10 on channel 3, 1000-cycle window
    half[3] = 5;
    issue(4'd3, 1000, 100, 1, 1'b0, 1'b0, "basic", 1'b1);
    chk("basic_ro_start", 32'(ro_start), 32'd1);
    wait_done(1100, "basic");
    @(negedge clk);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_ro_start", 32'(ro_start), 32'd0);

    // Channel isolation: period 8 on channel 7, period 20 elsewhere
    half[3] = 10;
    half[7] = 4;
    issue(4'd7, 800, 100, 1, 1'b0, 1'b0, "iso", 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("iso_ro_obs", 32'(ro_obs), 32'(ro_in[7]));
    end
    wait_done(900, "iso");

    // Out-of-range select falls back to channel 0 (period 10)
    half[7] = 10;
    half[0] = 5;
    issue(4'd12, 200, 20, 1, 1'b0, 1'b1, "selerr", 1'b1);
    wait_done(300, "selerr");

    // Zero-length window; in-range accept also clears sel_err
    issue(4'd3, 0, 0, 0, 1'b0, 1'b0, "win0", 1'b1);
    wait_done(40, "win0");

    // Start while busy is ignored
    half[3] = 5;
    d0 = done_seen;
    issue(4'd3, 300, 30, 1, 1'b0, 1'b0, "busystart", 1'b1);
    repeat (50) @(negedge clk);
    issue(4'd7, 10, 0, 0, 1'b0, 1'b0, "busystart2", 1'b0);
    wait_done(400, "busystart");
    repeat (300) @(negedge clk);
    chk("busystart_done_pulses", done_seen - d0, 32'd1);

    // Saturation: period 4 over 1100 cycles exceeds 8 bits
    half[3] = 2;
    issue(4'd3, 1100, 255, 0, 1'b1, 1'b0, "sat1", 1'b1);
    wait_done(1200, "sat1");

    // Abort mid-measure: no done, previous result kept
    d0 = done_seen;
    issue(4'd3, 1000, 0, 0, 1'b0, 1'b0, "abort", 1'b0);
    repeat (Settle + 50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ro_start", 32'(ro_start), 32'd0);
    repeat (1100) @(negedge clk);
    chk("abort_done_pulses", done_seen - d0, 32'd0);
    chk("abort_count_kept", 32'(count), 32'd255);
    chk("abort_overflow_kept", 32'(overflow), 32'd1);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_start_done_pulses", done_seen - d0, 32'd0);

    // Saturation rerun with a short window
    issue(4'd3, 80, 20, 1, 1'b0, 1'b0, "sat2", 1'b1);
    wait_done(200, "sat2");

    // Asynchronous reset mid-settle
    issue(4'd12, 500, 0, 0, 1'b0, 1'b1, "rstmid", 1'b0);
    chk("rstmid_sel_err_pre", 32'(sel_err), 32'd1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ro_start", 32'(ro_start), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_overflow", 32'(overflow), 32'd0);
    chk("rstmid_sel_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset
    issue(4'd3, 0, 0, 0, 1'b0, 1'b0, "recover", 1'b1);
    wait_done(40, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
